// File: rtl/wb_ram_responder.sv
// Wishbone B4 pipelined responder in front of a single-port 32-bit word RAM, one transaction at a time.
// Define WB_RAM_ERR_EN to add wb_err_o and error completions for addresses beyond DEPTH words.
module wb_ram_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 1,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
`ifdef WB_RAM_ERR_EN
  output logic        wb_err_o,
`endif
  output logic        wb_stall_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("wb_ram_responder: LATENCY must be within 1..15");
  end
  if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
    $error("wb_ram_responder: DEPTH must be a power of two >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            accept;
  logic            in_range;
  logic [AW-1:0]   word_idx;
  logic            we_p1;
  logic            err_p1;
  logic [31:0]     rdat_p1;
  logic            unused_adr_lsb;
  logic [31:0]     mem [DEPTH];

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  assign word_idx       = wb_adr_i[AW+1:2];
  assign unused_adr_lsb = ^wb_adr_i[1:0];
  assign accept         = wb_cyc_i & wb_stb_i & (state_q == S_IDLE);

`ifdef WB_RAM_ERR_EN
  assign in_range = (wb_adr_i[31:AW+2] == '0);
`else
  // Upper address bits are dropped, so out-of-range addresses wrap onto the array.
  logic unused_adr_msb;
  assign unused_adr_msb = ^wb_adr_i[31:AW+2];
  assign in_range       = 1'b1;
`endif

  // Accept edge -> p1: RAM access and read capture (read-before-write on one port)
  always_ff @(posedge clk_i) begin
    if (accept) begin
      rdat_p1 <= mem[word_idx];
      if (wb_we_i && in_range) begin
        mem[word_idx] <= merge_lanes(mem[word_idx], wb_dat_i, wb_sel_i);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_p1   <= 1'b0;
      err_p1  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_p1  <= wb_we_i;
        err_p1 <= ~in_range;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = S_RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Response: data is visible only during a successful read completion.
  always_comb begin
    wb_stall_o = (state_q != S_IDLE);
    wb_ack_o   = (state_q == S_RESP) & ~err_p1;
    wb_dat_o   = '0;
    if (state_q == S_RESP && !err_p1 && !we_p1) wb_dat_o = rdat_p1;
  end

`ifdef WB_RAM_ERR_EN
  assign wb_err_o = (state_q == S_RESP) & err_p1;
`endif

endmodule

// File: tb/tb_wb_ram_responder.sv
// Directed bench for wb_ram_responder: three instances with LATENCY 1, 3 and 4 share the bus fields.
module tb_wb_ram_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        cyc [3];
  logic        stb [3];
  logic        we_s;
  logic [3:0]  sel_s;
  logic [31:0] adr_s;
  logic [31:0] dat_s;
  logic [31:0] dat_w   [3];
  logic        ack_w   [3];
  logic        stall_w [3];
  logic        err_w   [3];

  int checks = 0;
  int errors = 0;

  wb_ram_responder #(.LATENCY(1)) u_l1 (
    .clk_i(clk), .rst_ni(rst_n), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]), .wb_we_i(we_s),
    .wb_sel_i(sel_s), .wb_adr_i(adr_s), .wb_dat_i(dat_s), .wb_dat_o(dat_w[0]),
    .wb_ack_o(ack_w[0]),
`ifdef WB_RAM_ERR_EN
    .wb_err_o(err_w[0]),
`endif
    .wb_stall_o(stall_w[0]));

  wb_ram_responder #(.LATENCY(3)) u_l3 (
    .clk_i(clk), .rst_ni(rst_n), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]), .wb_we_i(we_s),
    .wb_sel_i(sel_s), .wb_adr_i(adr_s), .wb_dat_i(dat_s), .wb_dat_o(dat_w[1]),
    .wb_ack_o(ack_w[1]),
`ifdef WB_RAM_ERR_EN
    .wb_err_o(err_w[1]),
`endif
    .wb_stall_o(stall_w[1]));

  wb_ram_responder #(.LATENCY(4)) u_l4 (
    .clk_i(clk), .rst_ni(rst_n), .wb_cyc_i(cyc[2]), .wb_stb_i(stb[2]), .wb_we_i(we_s),
    .wb_sel_i(sel_s), .wb_adr_i(adr_s), .wb_dat_i(dat_s), .wb_dat_o(dat_w[2]),
    .wb_ack_o(ack_w[2]),
`ifdef WB_RAM_ERR_EN
    .wb_err_o(err_w[2]),
`endif
    .wb_stall_o(stall_w[2]));

`ifndef WB_RAM_ERR_EN
  assign err_w[0] = 1'b0;
  assign err_w[1] = 1'b0;
  assign err_w[2] = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [31:0] exp_dat;
    logic        chk;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                              input logic [31:0] wdat, input logic [31:0] exp_dat,
                              input logic chk);
    vec_t v;
    v.we = we; v.sel = sel; v.adr = adr; v.wdat = wdat; v.exp_dat = exp_dat; v.chk = chk;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  // One transaction on instance d; reports completion data, flags and cycles to completion.
  task automatic xfer(input int d, input logic we, input logic [3:0] sel,
                      input logic [31:0] adr, input logic [31:0] dat,
                      output logic [31:0] rdat, output logic got_ack, output logic got_err,
                      output int lat, output logic stall_req);
    @(negedge clk);
    we_s = we; sel_s = sel; adr_s = adr; dat_s = dat;
    cyc[d] = 1'b1; stb[d] = 1'b1;
    stall_req = stall_w[d];
    @(negedge clk);
    cyc[d] = 1'b0; stb[d] = 1'b0;
    lat = 1; got_ack = 1'b0; got_err = 1'b0; rdat = '0;
    while (lat <= 20) begin
      if (ack_w[d] || err_w[d]) begin
        got_ack = ack_w[d];
        got_err = err_w[d];
        rdat    = dat_w[d];
        break;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        ga, ge, st;
    int          lat;

    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      cyc[d] = 1'b0;
      stb[d] = 1'b0;
    end
    we_s = 1'b0; sel_s = 4'h0; adr_s = '0; dat_s = '0;

    #12;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset_ack%0d", d), 32'(ack_w[d]), 0);
      chk($sformatf("reset_stall%0d", d), 32'(stall_w[d]), 0);
      chk($sformatf("reset_dat%0d", d), dat_w[d], 0);
      chk($sformatf("reset_err%0d", d), 32'(err_w[d]), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    tbl[0]  = mk(1'b1, 4'hF, 32'h010, 32'hDEADBEEF, 32'h0,        1'b0);
    tbl[1]  = mk(1'b0, 4'hF, 32'h010, 32'h0,        32'hDEADBEEF, 1'b1);
    tbl[2]  = mk(1'b0, 4'h1, 32'h010, 32'h0,        32'hDEADBEEF, 1'b1);
    tbl[3]  = mk(1'b1, 4'hF, 32'h020, 32'h11223344, 32'h0,        1'b0);
    tbl[4]  = mk(1'b1, 4'h2, 32'h021, 32'h0000AB00, 32'h0,        1'b0);
    tbl[5]  = mk(1'b0, 4'hF, 32'h020, 32'h0,        32'h1122AB44, 1'b1);
    tbl[6]  = mk(1'b1, 4'h0, 32'h020, 32'hFFFFFFFF, 32'h0,        1'b0);
    tbl[7]  = mk(1'b0, 4'hF, 32'h023, 32'h0,        32'h1122AB44, 1'b1);
    tbl[8]  = mk(1'b1, 4'h8, 32'h020, 32'hA5000000, 32'h0,        1'b0);
    tbl[9]  = mk(1'b0, 4'hF, 32'h020, 32'h0,        32'hA522AB44, 1'b1);
    tbl[10] = mk(1'b1, 4'hF, 32'h000, 32'hCAFEF00D, 32'h0,        1'b0);
    tbl[11] = mk(1'b1, 4'hF, 32'h004, 32'h01020304, 32'h0,        1'b0);
    tbl[12] = mk(1'b0, 4'hF, 32'h000, 32'h0,        32'hCAFEF00D, 1'b1);
    tbl[13] = mk(1'b1, 4'hF, 32'hFFC, 32'h12345678, 32'h0,        1'b0);
    tbl[14] = mk(1'b0, 4'hF, 32'hFFC, 32'h0,        32'h12345678, 1'b1);
    tbl[15] = mk(1'b0, 4'hF, 32'h004, 32'h0,        32'h01020304, 1'b1);

    for (int i = 0; i < 16; i++) begin
      xfer(0, tbl[i].we, tbl[i].sel, tbl[i].adr, tbl[i].wdat, rd, ga, ge, lat, st);
      chk($sformatf("v%0d_stall", i), 32'(st), 0);
      chk($sformatf("v%0d_ack", i), 32'(ga), 1);
      chk($sformatf("v%0d_lat", i), 32'(lat), 1);
      if (tbl[i].chk) chk($sformatf("v%0d_dat", i), rd, tbl[i].exp_dat);
    end

    // Out-of-range accesses: error completion or aliasing depending on build
    xfer(0, 1'b0, 4'hF, 32'h0001_0000, 32'h0, rd, ga, ge, lat, st);
    chk("oor_rd_lat", 32'(lat), 1);
`ifdef WB_RAM_ERR_EN
    chk("oor_rd_err", 32'(ge), 1);
    chk("oor_rd_ack", 32'(ga), 0);
    chk("oor_rd_dat", rd, 32'h0);
`else
    chk("oor_rd_err", 32'(ge), 0);
    chk("oor_rd_ack", 32'(ga), 1);
    chk("oor_rd_dat", rd, 32'hCAFEF00D);
`endif
    xfer(0, 1'b1, 4'hF, 32'h0001_0004, 32'h55555555, rd, ga, ge, lat, st);
`ifdef WB_RAM_ERR_EN
    chk("oor_wr_err", 32'(ge), 1);
`else
    chk("oor_wr_ack", 32'(ga), 1);
`endif
    xfer(0, 1'b0, 4'hF, 32'h0000_0004, 32'h0, rd, ga, ge, lat, st);
`ifdef WB_RAM_ERR_EN
    chk("oor_wr_kept", rd, 32'h01020304);
`else
    chk("oor_wr_alias", rd, 32'h55555555);
`endif

    // LATENCY=3 write, then async reset while a read waits
    xfer(1, 1'b1, 4'hF, 32'h040, 32'h0BADF00D, rd, ga, ge, lat, st);
    chk("l3_wr_ack", 32'(ga), 1);
    chk("l3_wr_lat", 32'(lat), 3);

    @(negedge clk);
    we_s = 1'b0; sel_s = 4'hF; adr_s = 32'h040;
    cyc[1] = 1'b1; stb[1] = 1'b1;
    @(negedge clk);
    cyc[1] = 1'b0; stb[1] = 1'b0;
    chk("rst_mid_stall_before", 32'(stall_w[1]), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_ack", 32'(ack_w[1]), 0);
    chk("rst_mid_stall", 32'(stall_w[1]), 0);
    chk("rst_mid_dat", dat_w[1], 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("rst_after_ack%0d", k), 32'(ack_w[1]), 0);
      chk($sformatf("rst_after_stall%0d", k), 32'(stall_w[1]), 0);
    end
    xfer(1, 1'b0, 4'hF, 32'h040, 32'h0, rd, ga, ge, lat, st);
    chk("rst_retain_ack", 32'(ga), 1);
    chk("rst_retain_lat", 32'(lat), 3);
    chk("rst_retain_dat", rd, 32'h0BADF00D);

    // Abort: cyc dropped during WAIT, completion still pulses, then a new request
    @(negedge clk);
    we_s = 1'b0; sel_s = 4'hF; adr_s = 32'h040;
    cyc[1] = 1'b1; stb[1] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      case (k)
        1: begin
          chk("abort_stall1", 32'(stall_w[1]), 1);
          cyc[1] = 1'b0; stb[1] = 1'b0;
        end
        2: begin
          chk("abort_ack2", 32'(ack_w[1]), 0);
          chk("abort_stall2", 32'(stall_w[1]), 1);
        end
        3: chk("abort_ack3", 32'(ack_w[1]), 1);
        4: begin
          chk("abort_stall4", 32'(stall_w[1]), 0);
          chk("abort_ack4", 32'(ack_w[1]), 0);
          cyc[1] = 1'b1; stb[1] = 1'b1;
        end
        5: begin
          chk("abort_new_stall5", 32'(stall_w[1]), 1);
          cyc[1] = 1'b0; stb[1] = 1'b0;
        end
        6: chk("abort_new_ack6", 32'(ack_w[1]), 0);
        default: begin
          chk("abort_new_ack7", 32'(ack_w[1]), 1);
          chk("abort_new_dat7", dat_w[1], 32'h0BADF00D);
        end
      endcase
    end

    // LATENCY=4 with the strobe held: accepts every 5 cycles
    xfer(2, 1'b1, 4'hF, 32'h000, 32'h77777777, rd, ga, ge, lat, st);
    chk("l4_wr_lat", 32'(lat), 4);
    @(negedge clk);
    we_s = 1'b0; sel_s = 4'hF; adr_s = 32'h000;
    cyc[2] = 1'b1; stb[2] = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      chk($sformatf("hold_stall%0d", k), 32'(stall_w[2]), 32'((k % 5) != 0));
      chk($sformatf("hold_ack%0d", k), 32'(ack_w[2]), 32'((k % 5) == 4));
      if ((k % 5) == 4) chk($sformatf("hold_dat%0d", k), dat_w[2], 32'h77777777);
    end
    cyc[2] = 1'b0; stb[2] = 1'b0;
    repeat (6) @(negedge clk);
    chk("hold_idle_stall", 32'(stall_w[2]), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
